alu_decode_stage: RTL
=====================

// Module: alu_decode_stage
// PURPOSE
//  Decode/issue stage that produces the ALU's input interface (aluop, opr_a, opr_b) from a RV32I instruction.
//  Decodes OP, OP-IMM, LUI and AUIPC; builds immediates; selects operands; registers the result in a
//  single-entry pipeline register with valid/ready handshakes on both sides. Sits between the register-file
//  read and the ALU input register. Latency 1 cycle.
// PARAMETERS
//  XLEN        32   datapath width; only 32 is supported
//  RESET_PC    0    value of out_pc after reset
// PORTS
//  clk         in   1     clock; all state updates on rising edge
//  rst_n       in   1     synchronous reset, active low
//  in_valid    in   1     upstream holds a valid instruction
//  in_ready    out  1     stage can accept an instruction this cycle
//  inst        in   32    instruction word
//  pc          in   32    instruction address
//  rs1_data    in   32    register-file value for inst[19:15]
//  rs2_data    in   32    register-file value for inst[24:20]
//  flush       in   1     discard the held entry and the entry offered this cycle
//  out_valid   out  1     decoded entry is valid
//  out_ready   in   1     ALU side consumes the entry this cycle
//  aluop       out  4     0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B
//  opr_a       out  32    ALU operand A
//  opr_b       out  32    ALU operand B
//  rd_addr     out  5     destination register, inst[11:7]
//  rd_wr       out  1     writeback enable; 0 when rd_addr==0 or illegal
//  illegal     out  1     instruction not decodable by this stage
//  out_pc      out  32    registered pc
// BEHAVIOUR
//  - Reset: out_valid=0, aluop=0000, opr_a=opr_b=0, rd_addr=0, rd_wr=0, illegal=0, out_pc=RESET_PC.
//  - Handshake: in_ready = !out_valid | out_ready (combinational). load = in_valid & in_ready & !flush.
//  - Next state: flush -> out_valid=0 (priority over load). Otherwise load -> capture decode, out_valid=1.
//    Otherwise out_ready -> out_valid=0. Otherwise hold.
//  - Outputs are stable while out_valid & !out_ready. Simultaneous consume and load gives back-to-back issue
//    with no bubble.
//  - Payload registers update only on load; they hold their old value when out_valid drops.
//  - Decode is combinational on inst; registered on load.
//    - OP (0110011): a=rs1_data, b=rs2_data. funct3 000 gives ADD/SUB (funct7 0000000/0100000).
//      001 SLL, 010 SLT, 011 SLTU, 100 XOR. 101 gives SRL/SRA (funct7 0000000/0100000). 110 OR, 111 AND.
//      Any other funct7 -> illegal.
//    - OP-IMM (0010011): a=rs1_data, b=sign-extended inst[31:20]. SLTIU compares against the sign-extended
//      immediate (unsigned compare).
//      - SLLI: inst[31:25] must be 0000000.
//      - SRLI/SRAI: inst[31:25] must be 0000000 or 0100000; b=inst[24:20] zero-extended.
//      - Any other shift encoding -> illegal.
//    - LUI (0110111): aluop=PASS_B, a=0, b={inst[31:12],12'b0}.
//    - AUIPC (0010111): aluop=ADD, a=pc, b={inst[31:12],12'b0}.
//    - Any other opcode, or inst[1:0]!=11 -> illegal=1, aluop=0000, a=b=0, rd_wr=0.
//  - An illegal entry still handshakes normally; trap handling is downstream.
//  - Reset mid-operation: in-flight entry is dropped, outputs return to reset values next edge.
//  - in_ready is still driven while rst_n=0; upstream must not treat it as acceptance.
// TESTING
//  1. ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, aluop=0000,
//     a=5, b=7, rd=3, rd_wr=1.
//  2. SRAI x5,x6,4 (0x40435293) -> aluop=0111, b=0x00000004.
//     ADDI x1,x0,-1 (0xFFF00093) -> aluop=0000, b=0xFFFFFFFF.
//  3. LUI x1,0x12345 (0x123450B7) -> aluop=1010, a=0, b=0x12345000.
//     AUIPC with pc=0x100 -> a=0x100, aluop=0000.
//  4. Back-pressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged.
//     On the cycle out_ready=1, the new instruction loads and out_valid stays 1.
//  5. flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the offered instruction is not captured.
//  6. ECALL (0x00000073) -> illegal=1, rd_wr=0, aluop=0000.
//     ADD x0,x1,x2 -> rd_wr=0.
//     rst_n=0 mid-stream -> out_valid=0 on the next edge.

Source files
------------

// File: rtl/alu_decode_stage_if.sv
// Handshake/payload bundle between the register-file read, the decode stage and the ALU input register.
interface alu_decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      aluop;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  logic [4:0]      rd_addr;
  logic            rd_wr;
  logic            illegal;
  logic [XLEN-1:0] out_pc;

  // Environment view: drives the instruction side and the consume strobe.
  modport master (
    output in_valid, inst, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, aluop, opr_a, opr_b, rd_addr, rd_wr, illegal, out_pc
  );

  // Stage view.
  modport slave (
    input  in_valid, inst, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, aluop, opr_a, opr_b, rd_addr, rd_wr, illegal, out_pc
  );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage: decodes OP, OP-IMM, LUI and AUIPC into ALU operation and operands,
// held in a single-entry valid/ready pipeline register.
module alu_decode_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  alu_decode_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SLT    = 4'b0011,
    ALU_SLTU   = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [6:0] {
    F7_BASE = 7'b0000000,
    F7_ALT  = 7'b0100000
  } funct7_e;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_field;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_sh;

  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_ill;
  logic            dec_wr;

  logic            valid_q;
  alu_op_e         op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [4:0]      rd_q;
  logic            wr_q;
  logic            ill_q;
  logic [XLEN-1:0] pc_q;

  logic            ready;
  logic            load;

  assign opcode   = bus.inst[6:0];
  assign funct3   = bus.inst[14:12];
  assign funct7   = bus.inst[31:25];
  assign rd_field = bus.inst[11:7];
  assign imm_i    = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};
  assign imm_u    = {{(XLEN-32){bus.inst[31]}}, bus.inst[31:12], 12'b0};
  assign imm_sh   = {{(XLEN-5){1'b0}}, bus.inst[24:20]};

  // Any opcode with inst[1:0] != 2'b11 misses every case item and falls into default.
  always_comb begin
    dec_op  = ALU_ADD;
    dec_a   = '0;
    dec_b   = '0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a = bus.rs1_data;
        dec_b = bus.rs2_data;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     dec_op = ALU_ADD;
            else if (funct7 == F7_ALT) dec_op = ALU_SUB;
            else                       dec_ill = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_op = ALU_SRA;
            else                       dec_ill = 1'b1;
          end
          default: begin
            if (funct7 != F7_BASE) dec_ill = 1'b1;
            case (funct3)
              3'b001:  dec_op = ALU_SLL;
              3'b010:  dec_op = ALU_SLT;
              3'b011:  dec_op = ALU_SLTU;
              3'b100:  dec_op = ALU_XOR;
              3'b110:  dec_op = ALU_OR;
              default: dec_op = ALU_AND;
            endcase
          end
        endcase
      end
      OPC_OP_IMM: begin
        dec_a = bus.rs1_data;
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_op = ALU_ADD;
          3'b001: begin
            dec_op = ALU_SLL;
            dec_b  = imm_sh;
            if (funct7 != F7_BASE) dec_ill = 1'b1;
          end
          3'b010: dec_op = ALU_SLT;
          3'b011: dec_op = ALU_SLTU;
          3'b100: dec_op = ALU_XOR;
          3'b101: begin
            dec_b = imm_sh;
            if (funct7 == F7_BASE)     dec_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_op = ALU_SRA;
            else                       dec_ill = 1'b1;
          end
          3'b110:  dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec_op = ALU_PASS_B;
        dec_b  = imm_u;
      end
      OPC_AUIPC: begin
        dec_op = ALU_ADD;
        dec_a  = bus.pc;
        dec_b  = imm_u;
      end
      default: dec_ill = 1'b1;
    endcase

    // Illegal entries carry a neutral payload so nothing downstream acts on stale operands.
    if (dec_ill) begin
      dec_op = ALU_ADD;
      dec_a  = '0;
      dec_b  = '0;
    end
  end

  assign dec_wr = !dec_ill && (rd_field != 5'd0);

  assign ready = !valid_q || bus.out_ready;
  assign load  = bus.in_valid && ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      if (bus.flush)         valid_q <= 1'b0;
      else if (load)         valid_q <= 1'b1;
      else if (bus.out_ready) valid_q <= 1'b0;

      if (load) begin
        op_q  <= dec_op;
        a_q   <= dec_a;
        b_q   <= dec_b;
        rd_q  <= rd_field;
        wr_q  <= dec_wr;
        ill_q <= dec_ill;
        pc_q  <= bus.pc;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.aluop     = op_q;
  assign bus.opr_a     = a_q;
  assign bus.opr_b     = b_q;
  assign bus.rd_addr   = rd_q;
  assign bus.rd_wr     = wr_q;
  assign bus.illegal   = ill_q;
  assign bus.out_pc    = pc_q;

endmodule
